// File: rtl/seq_core.sv
// seq_core: multi-cycle fetch/decode/execute/memory core for the 4-bit-opcode ISA.
// Holds the PC, register file and zero flag. It fetches over a req/ack
// instruction port and performs loads/stores over a req/ack data port.
// Either port may insert wait states.
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   instr_req/addr/ack/data  instruction fetch handshake (addr = pc)
//   mem_req/we/addr/wdata    data access request, held stable until mem_ack
//   mem_ack/rdata            data access completion and read data
//   pc, zero_flag            architectural PC and Z flag
//   halted, illegal          core stopped (HALT or undefined opcode)
//   dbg_idx/dbg_data         combinational register file read for debug
module seq_core #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REG_IDX_W = 2,
  parameter int unsigned IMM_W     = 8,
  localparam int unsigned INSTR_W  = 4 + REG_IDX_W + IMM_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 instr_req,
  output logic [IMM_W-1:0]     instr_addr,
  input  logic                 instr_ack,
  input  logic [INSTR_W-1:0]   instr_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [IMM_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [IMM_W-1:0]     pc,
  output logic                 zero_flag,
  output logic                 halted,
  output logic                 illegal,
  input  logic [REG_IDX_W-1:0] dbg_idx,
  output logic [DATA_W-1:0]    dbg_data
);

  localparam int unsigned NREG = 1 << REG_IDX_W;

  localparam logic [3:0] OP_MOVIR = 4'h0;
  localparam logic [3:0] OP_MOVRR = 4'h1;
  localparam logic [3:0] OP_MOVMR = 4'h2;
  localparam logic [3:0] OP_MOVRM = 4'h3;
  localparam logic [3:0] OP_ADDRR = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUBRR = 4'h6;
  localparam logic [3:0] OP_SUBI  = 4'h7;
  localparam logic [3:0] OP_JZI   = 4'h8;
  localparam logic [3:0] OP_JZR   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hE;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  state_t               state;
  logic [INSTR_W-1:0]   ir;
  logic [DATA_W-1:0]    regs [NREG];

  logic [3:0]           op;
  logic [REG_IDX_W-1:0] rd, rs, rt;
  logic [IMM_W-1:0]     imm;
  logic [DATA_W-1:0]    imm_d, rd_v, rs_v, rt_v;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_wr, alu_zupd;
  logic                 op_illegal, jump_taken;
  logic [IMM_W-1:0]     jump_tgt;

  // Instruction field extraction from the latched IR
  assign op    = ir[INSTR_W-1 -: 4];
  assign rd    = ir[IMM_W +: REG_IDX_W];
  assign imm   = ir[IMM_W-1:0];
  assign rs    = imm[IMM_W-1 -: REG_IDX_W];
  assign rt    = imm[IMM_W-REG_IDX_W-1 -: REG_IDX_W];
  assign imm_d = DATA_W'(imm);
  assign rd_v  = regs[rd];
  assign rs_v  = regs[rs];
  assign rt_v  = regs[rt];

  assign instr_addr = pc;
  assign dbg_data   = regs[dbg_idx];

  assign op_illegal = (op >= 4'hA) && (op <= 4'hD);
  assign jump_taken = zero_flag && ((op == OP_JZI) || (op == OP_JZR));
  assign jump_tgt   = (op == OP_JZI) ? imm : IMM_W'(rd_v);

  // Register-writing result for EXEC; only the arithmetic ops touch Z
  always_comb begin
    alu_res  = '0;
    alu_wr   = 1'b0;
    alu_zupd = 1'b0;
    case (op)
      OP_MOVIR: begin alu_res = imm_d;       alu_wr = 1'b1; end
      OP_MOVRR: begin alu_res = rs_v;        alu_wr = 1'b1; end
      OP_ADDRR: begin alu_res = rs_v + rt_v; alu_wr = 1'b1; alu_zupd = 1'b1; end
      OP_ADDI:  begin alu_res = rd_v + imm_d; alu_wr = 1'b1; alu_zupd = 1'b1; end
      OP_SUBRR: begin alu_res = rs_v - rt_v; alu_wr = 1'b1; alu_zupd = 1'b1; end
      OP_SUBI:  begin alu_res = rd_v - imm_d; alu_wr = 1'b1; alu_zupd = 1'b1; end
      default:  ;
    endcase
  end

  // Control FSM; request lines are registered and raised on entry to their state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      regs      <= '{default: '0};
      zero_flag <= 1'b0;
      instr_req <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // First cycle after reset arrives here with the request still low
          if (!instr_req) begin
            instr_req <= 1'b1;
          end else if (instr_ack) begin
            ir        <= instr_data;
            pc        <= pc + 1'b1;
            instr_req <= 1'b0;
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op_illegal) begin
            illegal <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if ((op == OP_MOVMR) || (op == OP_MOVRM)) begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_MOVRM);
            mem_addr  <= imm;
            mem_wdata <= rd_v;
            state     <= S_MEM;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (alu_wr)     regs[rd]  <= alu_res;
          if (alu_zupd)   zero_flag <= (alu_res == '0);
          if (jump_taken) pc        <= jump_tgt;
          instr_req <= 1'b1;
          state     <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ack) begin
            if (!mem_we) regs[rd] <= mem_rdata;
            mem_req   <= 1'b0;
            instr_req <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_core.sv
// Directed bench for seq_core: a ROM/RAM responder pair with programmable wait
// states feeds the core. A scoreboard of expected fetch addresses and data
// accesses is consumed by a separate monitor on every handshake.
module tb_seq_core;

  localparam logic [3:0] OP_MOVIR = 4'h0;
  localparam logic [3:0] OP_MOVMR = 4'h2;
  localparam logic [3:0] OP_MOVRM = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUBRR = 4'h6;
  localparam logic [3:0] OP_SUBI  = 4'h7;
  localparam logic [3:0] OP_JZI   = 4'h8;
  localparam logic [3:0] OP_JZR   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } mexp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req, instr_ack;
  logic [7:0]  instr_addr;
  logic [13:0] instr_data;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  pc;
  logic        zero_flag, halted, illegal;
  logic [1:0]  dbg_idx;
  logic [7:0]  dbg_data;

  logic [13:0] imem [256];
  logic [7:0]  dmem [256];
  int          iwait, dwait;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  fq [$];
  mexp_t       mq [$];

  seq_core dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc(pc), .zero_flag(zero_flag), .halted(halted), .illegal(illegal),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] enc(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Instruction ROM responder
  initial begin
    int cnt;
    cnt = 0;
    instr_ack = 1'b0;
    instr_data = '0;
    forever begin
      @(negedge clk);
      if (instr_req) begin
        if (cnt >= iwait) begin
          instr_ack = 1'b1;
          instr_data = imem[instr_addr];
          cnt = 0;
        end else begin
          instr_ack = 1'b0;
          cnt++;
        end
      end else begin
        instr_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Data RAM responder
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (cnt >= dwait) begin
          mem_ack = 1'b1;
          if (mem_we) dmem[mem_addr] = mem_wdata;
          else        mem_rdata = dmem[mem_addr];
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: every completed handshake consumes one scoreboard entry
  initial begin
    logic [7:0] ea;
    mexp_t      em;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && instr_req && instr_ack) begin
        if (fq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL fetch_unexpected: got addr 0x%0h, required no fetch", instr_addr);
        end else begin
          ea = fq.pop_front();
          chk("fetch_addr", 32'(instr_addr), 32'(ea));
        end
      end
      if (reset_n && mem_req && mem_ack) begin
        if (mq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mem_unexpected: got addr 0x%0h, required no access", mem_addr);
        end else begin
          em = mq.pop_front();
          chk("mem_we", 32'(mem_we), 32'(em.we));
          chk("mem_addr", 32'(mem_addr), 32'(em.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(em.wdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i[7:0]] = enc(OP_HALT, 2'd0, 8'h00);
      dmem[i[7:0]] = '0;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    fq.delete();
    mq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_halted(input string name);
    int c;
    c = 0;
    while (!halted && c < 300) begin @(negedge clk); c++; end
    chk(name, 32'(halted), 1);
  endtask

  task automatic wait_instr_req(input string name);
    int c;
    c = 0;
    while (!instr_req && c < 50) begin @(negedge clk); c++; end
    chk(name, 32'(instr_req), 1);
  endtask

  task automatic wait_mem_req(input string name);
    int c;
    c = 0;
    while (!mem_req && c < 50) begin @(negedge clk); c++; end
    chk(name, 32'(mem_req), 1);
  endtask

  task automatic seg_end(input string name);
    @(negedge clk);
    chk({name, "_fetch_left"}, 32'(fq.size()), 0);
    chk({name, "_mem_left"}, 32'(mq.size()), 0);
  endtask

  initial begin
    logic [5:0] reqs;
    int c, nreq;
    reset_n = 1'b0;
    dbg_idx = 2'd0;
    iwait = 0;
    dwait = 0;
    clear_mem();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_instr_req", 32'(instr_req), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_zero", 32'(zero_flag), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);
    for (int i = 0; i < 4; i++) begin
      dbg_idx = i[1:0];
      #1;
      chk("rst_reg", 32'(dbg_data), 0);
    end

    // Zero-wait MOVIR r1,0x05 ; ADDI r1,0xFB -> r1 = 0, Z = 1
    imem[0] = enc(OP_MOVIR, 2'd1, 8'h05);
    imem[1] = enc(OP_ADDI, 2'd1, 8'hFB);
    dbg_idx = 2'd1;
    apply_reset();
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h02);
    wait_instr_req("a_first_req");
    reqs[0] = instr_req;
    for (int k = 1; k < 6; k++) begin @(negedge clk); reqs[k] = instr_req; end
    chk("a_req_pattern", 32'(reqs), 'h09);
    @(negedge clk);
    chk("a_pc", 32'(pc), 2);
    chk("a_r1", 32'(dbg_data), 0);
    chk("a_zero", 32'(zero_flag), 1);
    wait_halted("a_halted");
    chk("a_illegal", 32'(illegal), 0);
    seg_end("a");

    // SUBRR r2,r0,r1 with r1 = 1 -> 0xFF, Z = 0 ; JZI not taken
    clear_mem();
    iwait = 1;
    imem[0] = enc(OP_MOVIR, 2'd1, 8'h01);
    imem[1] = enc(OP_SUBRR, 2'd2, 8'h10);
    imem[2] = enc(OP_JZI, 2'd0, 8'h40);
    dbg_idx = 2'd2;
    apply_reset();
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    wait_halted("b_halted");
    chk("b_r2", 32'(dbg_data), 'hFF);
    chk("b_zero", 32'(zero_flag), 0);
    chk("b_pc", 32'(pc), 4);
    seg_end("b");

    // Store/load with three data wait states
    clear_mem();
    iwait = 0;
    dwait = 3;
    imem[0] = enc(OP_MOVIR, 2'd3, 8'hA5);
    imem[1] = enc(OP_MOVRM, 2'd3, 8'h10);
    imem[2] = enc(OP_MOVMR, 2'd0, 8'h10);
    dbg_idx = 2'd0;
    apply_reset();
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    mq.push_back('{we: 1'b1, addr: 8'h10, wdata: 8'hA5});
    mq.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    wait_mem_req("c_store_req");
    c = 0;
    while (mem_req && c < 20) begin
      chk("c_hold_we", 32'(mem_we), 1);
      chk("c_hold_addr", 32'(mem_addr), 'h10);
      chk("c_hold_wdata", 32'(mem_wdata), 'hA5);
      c++;
      @(negedge clk);
    end
    chk("c_req_cycles", 32'(c), 4);
    wait_halted("c_halted");
    chk("c_r0", 32'(dbg_data), 'hA5);
    seg_end("c");

    // Illegal opcode 1011 stops the core with no further fetches
    clear_mem();
    dwait = 0;
    imem[0] = enc(4'hB, 2'd0, 8'h00);
    apply_reset();
    fq.push_back(8'h00);
    wait_halted("d_halted");
    chk("d_illegal", 32'(illegal), 1);
    nreq = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (instr_req) nreq++; end
    chk("d_req_after_halt", 32'(nreq), 0);
    chk("d_pc", 32'(pc), 1);
    seg_end("d");

    // PC wrap through NOP at 0xFF, then JZR to r2 = 0x22
    clear_mem();
    iwait = 2;
    imem[8'h00] = enc(OP_JZI, 2'd0, 8'h10);
    imem[8'h01] = enc(OP_MOVIR, 2'd2, 8'h22);
    imem[8'h02] = enc(OP_SUBI, 2'd0, 8'h00);
    imem[8'h03] = enc(OP_JZI, 2'd0, 8'hFF);
    imem[8'hFF] = enc(OP_NOP, 2'd0, 8'h00);
    imem[8'h10] = enc(OP_JZR, 2'd2, 8'h00);
    dbg_idx = 2'd2;
    apply_reset();
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    fq.push_back(8'hFF); fq.push_back(8'h00); fq.push_back(8'h10); fq.push_back(8'h22);
    wait_halted("e_halted");
    chk("e_pc", 32'(pc), 'h23);
    chk("e_r2", 32'(dbg_data), 'h22);
    chk("e_zero", 32'(zero_flag), 1);
    seg_end("e");

    // Reset during a stalled store clears outputs asynchronously
    clear_mem();
    iwait = 0;
    dwait = 1000;
    imem[0] = enc(OP_MOVIR, 2'd0, 8'h77);
    imem[1] = enc(OP_MOVRM, 2'd0, 8'h33);
    dbg_idx = 2'd0;
    apply_reset();
    fq.push_back(8'h00); fq.push_back(8'h01);
    wait_mem_req("f_store_req");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("f_async_mem_req", 32'(mem_req), 0);
    chk("f_async_mem_we", 32'(mem_we), 0);
    chk("f_async_mem_addr", 32'(mem_addr), 0);
    chk("f_async_mem_wdata", 32'(mem_wdata), 0);
    chk("f_async_instr_req", 32'(instr_req), 0);
    chk("f_async_pc", 32'(pc), 0);
    chk("f_async_r0", 32'(dbg_data), 0);
    @(negedge clk);
    chk("f_fetch_left_before_restart", 32'(fq.size()), 0);
    reset_n = 1'b1;
    fq.push_back(8'h00);
    wait_instr_req("f_restart_req");
    chk("f_restart_addr", 32'(instr_addr), 0);
    seg_end("f");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
